// File: rtl/leds_pkg.sv
// Shared constants for the LED / button demo ports.
package leds_pkg;

  // Width of the board LED port; the button port matches it by default.
  localparam int unsigned LED_WIDTH = 8;

  // Board buttons pull the pin low when pressed.
  localparam bit BUTTON_ACTIVE_LOW = 1'b1;

  // 1 ms of stable level at a 25 MHz system clock.
  localparam int unsigned DEBOUNCE_1MS_25MHZ = 25000;

  // Short debounce window so simulations stay fast.
  localparam int unsigned DEBOUNCE_SIM = 4;

  // Two flops are enough for the board clock rate.
  localparam int unsigned BUTTON_SYNC_STAGES = 2;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One button bit: synchronizer, saturating debounce counter, accepted level
// and single-cycle press/release pulses.
module debounce_bit
  import leds_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_1MS_25MHZ,
  parameter int unsigned SYNC_STAGES     = BUTTON_SYNC_STAGES,
  parameter bit          ACTIVE_LOW      = BUTTON_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,        // raw asynchronous pin
  output logic state_o,      // debounced level, 1 = pressed
  output logic press_o,      // registered pulse on accepted 0->1
  output logic release_o,    // registered pulse on accepted 1->0
  output logic press_next_o  // value press_o takes at the next edge
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  // Pin level when the button is not pressed.
  localparam logic            IDLE_LVL = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   state_q, state_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   s;

  // Shift the raw pin through the synchronizer and normalize to 1 = pressed.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
    s      = sync_q[SYNC_STAGES-1] ^ IDLE_LVL;
  end

  // Count consecutive cycles where the synchronized level disagrees with the
  // accepted level; any agreeing cycle throws the partial count away.
  always_comb begin
    cnt_d     = '0;
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s != state_q) begin
      if (cnt_q == CNT_MAX) begin
        state_d   = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Registers; the synchronizer preloads the idle pin level so leaving reset
  // with the button up never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= {SYNC_STAGES{IDLE_LVL}};
      cnt_q     <= '0;
      state_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign state_o      = state_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign press_next_o = rst ? 1'b0 : press_d;

endmodule

// File: rtl/button_port_in.sv
// Button/switch input port: WIDTH independent debounced bits plus a
// registered "any button pressed" pulse.
// `release` is a reserved word in SystemVerilog, so that port is spelled
// release_pulse.
module button_port_in
  import leds_pkg::*;
#(
  parameter int unsigned WIDTH           = LED_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_1MS_25MHZ,
  parameter int unsigned SYNC_STAGES     = BUTTON_SYNC_STAGES,
  parameter bit          ACTIVE_LOW      = BUTTON_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] BPORT,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_press
);

  logic [WIDTH-1:0] press_next;
  logic             any_press_q, any_press_d;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .clk          (clk),
      .rst          (rst),
      .pin_i        (BPORT[i]),
      .state_o      (state[i]),
      .press_o      (press[i]),
      .release_o    (release_pulse[i]),
      .press_next_o (press_next[i])
    );
  end

  // OR of the per-bit next press values, so any_press lines up with press.
  always_comb begin
    any_press_d = |press_next;
  end

  // any_press register.
  always_ff @(posedge clk) begin
    if (rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign any_press = any_press_q;

endmodule
